// File: rtl/nn_load_sequencer.sv
`default_nettype none
// nn_load_sequencer: streams input and parameter bytes from a byte-wide memory
// into neural_network, pulses its change strobe and captures the network output.
module nn_load_sequencer #(
  parameter int N_INPUTS    = 4,
  parameter int N_NEURONS   = 4,
  parameter int DW          = 8,
  parameter int AW          = 5,
  parameter int RESULT_WAIT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          skip_params,
  input  logic          abort,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] nn_data,
  output logic          nn_valid,
  output logic          nn_changes,
  input  logic [DW-1:0] nn_result,
  output logic [DW-1:0] result,
  output logic          result_valid,
  output logic          busy
);

  localparam int P_BYTES = N_NEURONS * (N_INPUTS + 2);
  localparam int CW      = $clog2(RESULT_WAIT + 2);

  localparam logic [AW-1:0] X_LAST    = AW'(N_INPUTS - 1);
  localparam logic [AW-1:0] P_FIRST   = AW'(N_INPUTS);
  localparam logic [AW-1:0] P_LAST    = AW'(N_INPUTS + P_BYTES - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(RESULT_WAIT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_X     = 3'd1,
    PULSE_X  = 3'd2,
    RD_P     = 3'd3,
    PULSE_P  = 3'd4,
    WAIT_RES = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] addr_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          full_load;
  logic          full_nx;
  logic          params_loaded;
  logic          final_seen;

  logic          start_ok;
  logic          abort_busy;
  logic          mark;
  logic          mark_last;

  // Read-side pipeline: one stage for the memory latency, one for the output register.
  logic          rd_d1;
  logic          mark_d1;
  logic          last_d1;

  assign start_ok   = (state == IDLE) && start && !abort;
  assign abort_busy = (state != IDLE) && abort;

  // Issue-stage decode; the PULSE states are empty slots in the read stream
  // that surface as nn_changes two cycles later, between data bursts.
  assign mem_rd    = (state == RD_X) || (state == RD_P);
  assign mark      = (state == PULSE_X) || (state == PULSE_P);
  assign mark_last = ((state == PULSE_X) && !full_load) || (state == PULSE_P);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx = state;
    addr_nx  = mem_addr;
    cnt_nx   = cnt;
    full_nx  = full_load;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nx = RD_X;
          addr_nx  = '0;
          full_nx  = !(skip_params && params_loaded);
        end
      end
      RD_X: begin
        if (mem_addr == X_LAST) state_nx = PULSE_X;
        else                    addr_nx  = mem_addr + 1'b1;
      end
      PULSE_X: begin
        if (full_load) begin
          state_nx = RD_P;
          addr_nx  = P_FIRST;
        end else begin
          state_nx = WAIT_RES;
          cnt_nx   = '0;
        end
      end
      RD_P: begin
        if (mem_addr == P_LAST) state_nx = PULSE_P;
        else                    addr_nx  = mem_addr + 1'b1;
      end
      PULSE_P: begin
        state_nx = WAIT_RES;
        cnt_nx   = '0;
      end
      WAIT_RES: begin
        if (cnt == WAIT_LAST) state_nx = DONE;
        else                  cnt_nx   = cnt + 1'b1;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    if (abort_busy) begin
      state_nx = IDLE;
      addr_nx  = mem_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      mem_addr  <= '0;
      cnt       <= '0;
      full_load <= 1'b0;
    end else begin
      state     <= state_nx;
      mem_addr  <= addr_nx;
      cnt       <= cnt_nx;
      full_load <= full_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_d1         <= 1'b0;
      mark_d1       <= 1'b0;
      last_d1       <= 1'b0;
      nn_data       <= '0;
      nn_valid      <= 1'b0;
      nn_changes    <= 1'b0;
      result        <= '0;
      result_valid  <= 1'b0;
      params_loaded <= 1'b0;
      final_seen    <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (abort_busy) begin
        rd_d1      <= 1'b0;
        mark_d1    <= 1'b0;
        last_d1    <= 1'b0;
        nn_data    <= '0;
        nn_valid   <= 1'b0;
        nn_changes <= 1'b0;
        // Weights are only trusted once the network has seen the closing pulse.
        if (!final_seen) params_loaded <= 1'b0;
      end else begin
        rd_d1      <= mem_rd;
        mark_d1    <= mark;
        last_d1    <= mark_last;
        nn_valid   <= rd_d1;
        nn_data    <= rd_d1 ? mem_rdata : '0;
        nn_changes <= mark_d1;
        if (start_ok) final_seen <= 1'b0;
        if (mark_d1 && last_d1) begin
          final_seen <= 1'b1;
          if (full_load) params_loaded <= 1'b1;
        end
        if (state == DONE) begin
          result       <= nn_result;
          result_valid <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nn_load_sequencer.sv
`default_nettype none
// Directed self-checking bench for nn_load_sequencer; cycle schedules are
// derived from the load timeline (cycle 0 = edge that samples start).
module tb_nn_load_sequencer;
  localparam int NI = 4;
  localparam int P  = 24;
  localparam int RW = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       skip_params;
  logic       abort;
  logic       mem_rd;
  logic [4:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [7:0] nn_data;
  logic       nn_valid;
  logic       nn_changes;
  logic [7:0] nn_result;
  logic [7:0] result;
  logic       result_valid;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem     [0:31];
  logic [4:0] tr_ctl  [0:63];  // {busy, mem_rd, nn_valid, nn_changes, result_valid}
  logic [4:0] tr_addr [0:63];
  logic [7:0] tr_data [0:63];
  logic [7:0] tr_res  [0:63];

  always #5 clk = ~clk;

  nn_load_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .skip_params  (skip_params),
    .abort        (abort),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .nn_data      (nn_data),
    .nn_valid     (nn_valid),
    .nn_changes   (nn_changes),
    .nn_result    (nn_result),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy)
  );

  // Memory with one cycle of read latency; garbage when not read.
  always @(posedge clk) mem_rdata <= mem_rd ? mem[mem_addr] : 8'hEE;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  function automatic logic [4:0] exp_ctl(input int k, input bit full);
    int   c2;
    logic b, rd, v, ch, rv;
    c2 = full ? (NI + 4 + P) : (NI + 3);
    b  = (k >= 1) && (k <= c2 + RW);
    rd = ((k >= 1) && (k <= NI)) || (full && (k >= NI + 2) && (k <= NI + 1 + P));
    v  = ((k >= 3) && (k <= NI + 2)) || (full && (k >= NI + 4) && (k <= NI + 3 + P));
    ch = (k == NI + 3) || (full && (k == NI + 4 + P));
    rv = (k == c2 + RW + 1);
    return {b, rd, v, ch, rv};
  endfunction

  function automatic logic [7:0] exp_data(input int k, input bit full);
    if ((k >= 3) && (k <= NI + 2)) return mem[k - 3];
    if (full && (k >= NI + 4) && (k <= NI + 3 + P)) return mem[k - 4];
    return 8'h00;
  endfunction

  function automatic logic [4:0] exp_addr(input int k);
    if (k <= NI) return 5'(k - 1);
    return 5'(k - 2);
  endfunction

  // Pulses start in cycle 0, records cycles 1..ncyc, and injects extra
  // start/abort/reset events in the given cycles (-1 = none).
  task automatic run_seq(input logic skip, input logic [7:0] res_in, input int ncyc,
                         input int s1, input int s2, input int s3, input int ab, input int rs);
    nn_result = res_in;
    @(negedge clk);
    start = 1'b1; skip_params = skip; abort = 1'b0; reset = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; reset = 1'b1;
      tr_ctl[k]  = {busy, mem_rd, nn_valid, nn_changes, result_valid};
      tr_addr[k] = mem_addr;
      tr_data[k] = nn_data;
      tr_res[k]  = result;
      if (k == s1 || k == s2 || k == s3) start = 1'b1;
      if (k == ab) abort = 1'b1;
      if (k == rs) reset = 1'b0;
    end
    start = 1'b0; abort = 1'b0; reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (mem_rd !== 1'b0)       begin n_err++; $display("FAIL rst_mem_rd got=%b exp=0", mem_rd); end
    n_cmp++; if (mem_addr !== 5'd0)     begin n_err++; $display("FAIL rst_mem_addr got=%0d exp=0", mem_addr); end
    n_cmp++; if (nn_data !== 8'd0)      begin n_err++; $display("FAIL rst_nn_data got=%h exp=00", nn_data); end
    n_cmp++; if (nn_valid !== 1'b0)     begin n_err++; $display("FAIL rst_nn_valid got=%b exp=0", nn_valid); end
    n_cmp++; if (nn_changes !== 1'b0)   begin n_err++; $display("FAIL rst_nn_changes got=%b exp=0", nn_changes); end
    n_cmp++; if (result !== 8'd0)       begin n_err++; $display("FAIL rst_result got=%h exp=00", result); end
    n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL rst_result_valid got=%b exp=0", result_valid); end
    n_cmp++; if (busy !== 1'b0)         begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
    reset = 1'b1;
  endtask

  task automatic test_full_load();
    run_seq(1'b0, 8'h5A, 35, -1, -1, -1, -1, -1);
    for (int k = 1; k <= 35; k++) begin
      logic [4:0] e;
      e = exp_ctl(k, 1'b1);
      n_cmp++;
      if (tr_ctl[k] !== e) begin n_err++; $display("FAIL full_ctl cyc=%0d got=%b exp=%b", k, tr_ctl[k], e); end
      n_cmp++;
      if (tr_data[k] !== exp_data(k, 1'b1)) begin
        n_err++; $display("FAIL full_data cyc=%0d got=%h exp=%h", k, tr_data[k], exp_data(k, 1'b1));
      end
      if (e[3]) begin
        n_cmp++;
        if (tr_addr[k] !== exp_addr(k)) begin
          n_err++; $display("FAIL full_addr cyc=%0d got=%0d exp=%0d", k, tr_addr[k], exp_addr(k));
        end
      end
    end
    n_cmp++; if (tr_addr[5] !== 5'd3)   begin n_err++; $display("FAIL full_addr_hold5 got=%0d exp=3", tr_addr[5]); end
    n_cmp++; if (tr_addr[33] !== 5'd27) begin n_err++; $display("FAIL full_addr_hold33 got=%0d exp=27", tr_addr[33]); end
    n_cmp++; if (tr_res[34] !== 8'h00)  begin n_err++; $display("FAIL full_res_pre got=%h exp=00", tr_res[34]); end
    n_cmp++; if (tr_res[35] !== 8'h5A)  begin n_err++; $display("FAIL full_result got=%h exp=5a", tr_res[35]); end
  endtask

  task automatic test_skip_load();
    int reads;
    reads = 0;
    run_seq(1'b1, 8'h33, 10, -1, -1, -1, -1, -1);
    for (int k = 1; k <= 10; k++) begin
      n_cmp++;
      if (tr_ctl[k] !== exp_ctl(k, 1'b0)) begin
        n_err++; $display("FAIL skip_ctl cyc=%0d got=%b exp=%b", k, tr_ctl[k], exp_ctl(k, 1'b0));
      end
      n_cmp++;
      if (tr_data[k] !== exp_data(k, 1'b0)) begin
        n_err++; $display("FAIL skip_data cyc=%0d got=%h exp=%h", k, tr_data[k], exp_data(k, 1'b0));
      end
      if (tr_ctl[k][3] === 1'b1) reads++;
    end
    n_cmp++; if (reads != 4)           begin n_err++; $display("FAIL skip_reads got=%0d exp=4", reads); end
    n_cmp++; if (tr_res[9] !== 8'h5A)  begin n_err++; $display("FAIL skip_res_hold got=%h exp=5a", tr_res[9]); end
    n_cmp++; if (tr_res[10] !== 8'h33) begin n_err++; $display("FAIL skip_result got=%h exp=33", tr_res[10]); end
  endtask

  task automatic test_skip_after_reset();
    int reads;
    reads = 0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_seq(1'b1, 8'h6B, 35, -1, -1, -1, -1, -1);
    for (int k = 1; k <= 35; k++) begin
      n_cmp++;
      if (tr_ctl[k] !== exp_ctl(k, 1'b1)) begin
        n_err++; $display("FAIL rstskip_ctl cyc=%0d got=%b exp=%b", k, tr_ctl[k], exp_ctl(k, 1'b1));
      end
      if (tr_ctl[k][3] === 1'b1) reads++;
    end
    n_cmp++; if (reads != 28)          begin n_err++; $display("FAIL rstskip_reads got=%0d exp=28", reads); end
    n_cmp++; if (tr_res[35] !== 8'h6B) begin n_err++; $display("FAIL rstskip_result got=%h exp=6b", tr_res[35]); end
  endtask

  task automatic test_back_to_back();
    int rvs;
    rvs = 0;
    run_seq(1'b0, 8'h4C, 36, 5, 20, 35, -1, -1);
    for (int k = 1; k <= 35; k++) begin
      n_cmp++;
      if (tr_ctl[k] !== exp_ctl(k, 1'b1)) begin
        n_err++; $display("FAIL ign_ctl cyc=%0d got=%b exp=%b", k, tr_ctl[k], exp_ctl(k, 1'b1));
      end
      if (tr_ctl[k][0] === 1'b1) rvs++;
    end
    n_cmp++; if (rvs != 1) begin n_err++; $display("FAIL ign_rv_count got=%0d exp=1", rvs); end
    n_cmp++;
    if ({tr_ctl[36][3], tr_addr[36]} !== {1'b1, 5'd0}) begin
      n_err++; $display("FAIL b2b_first_read got rd=%b addr=%0d exp rd=1 addr=0", tr_ctl[36][3], tr_addr[36]);
    end
    for (int i = 0; i < 60; i++) begin
      if (busy === 1'b0) break;
      @(negedge clk);
    end
    n_cmp++;
    if ({busy, result_valid, result} !== {1'b0, 1'b1, 8'h4C}) begin
      n_err++; $display("FAIL b2b_end got busy=%b rv=%b res=%h exp busy=0 rv=1 res=4c", busy, result_valid, result);
    end
  endtask

  task automatic test_abort();
    run_seq(1'b0, 8'h77, 40, -1, -1, -1, 15, -1);
    for (int k = 1; k <= 15; k++) begin
      n_cmp++;
      if (tr_ctl[k] !== exp_ctl(k, 1'b1)) begin
        n_err++; $display("FAIL abort_pre cyc=%0d got=%b exp=%b", k, tr_ctl[k], exp_ctl(k, 1'b1));
      end
    end
    for (int k = 16; k <= 40; k++) begin
      n_cmp++;
      if (tr_ctl[k] !== 5'b00000) begin n_err++; $display("FAIL abort_idle cyc=%0d got=%b exp=00000", k, tr_ctl[k]); end
    end
    n_cmp++; if (tr_res[16] !== 8'h4C) begin n_err++; $display("FAIL abort_result got=%h exp=4c", tr_res[16]); end
    n_cmp++; if (tr_data[16] !== 8'h00) begin n_err++; $display("FAIL abort_data got=%h exp=00", tr_data[16]); end
    run_seq(1'b1, 8'h21, 35, -1, -1, -1, -1, -1);
    for (int k = 1; k <= 35; k++) begin
      n_cmp++;
      if (tr_ctl[k] !== exp_ctl(k, 1'b1)) begin
        n_err++; $display("FAIL abort_reload cyc=%0d got=%b exp=%b", k, tr_ctl[k], exp_ctl(k, 1'b1));
      end
    end
    n_cmp++; if (tr_res[35] !== 8'h21) begin n_err++; $display("FAIL abort_reload_res got=%h exp=21", tr_res[35]); end
  endtask

  task automatic test_abort_idle();
    @(negedge clk);
    start = 1'b1; abort = 1'b1; skip_params = 1'b0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    n_cmp++;
    if ({busy, mem_rd} !== 2'b00) begin n_err++; $display("FAIL abort_start got busy=%b rd=%b exp 0 0", busy, mem_rd); end
    @(negedge clk);
    n_cmp++;
    if ({busy, mem_rd, result} !== {2'b00, 8'h21}) begin
      n_err++; $display("FAIL abort_start_late got busy=%b rd=%b res=%h exp 0 0 21", busy, mem_rd, result);
    end
  endtask

  task automatic test_reset_mid();
    run_seq(1'b0, 8'h99, 40, -1, -1, -1, -1, 20);
    for (int k = 1; k <= 20; k++) begin
      n_cmp++;
      if (tr_ctl[k] !== exp_ctl(k, 1'b1)) begin
        n_err++; $display("FAIL rstmid_pre cyc=%0d got=%b exp=%b", k, tr_ctl[k], exp_ctl(k, 1'b1));
      end
    end
    n_cmp++;
    if ({tr_addr[21], tr_data[21], tr_res[21]} !== 21'd0) begin
      n_err++; $display("FAIL rstmid_regs got addr=%0d data=%h res=%h exp 0", tr_addr[21], tr_data[21], tr_res[21]);
    end
    for (int k = 21; k <= 40; k++) begin
      n_cmp++;
      if ({tr_ctl[k], tr_res[k]} !== 13'd0) begin
        n_err++; $display("FAIL rstmid_quiet cyc=%0d got ctl=%b res=%h exp 0", k, tr_ctl[k], tr_res[k]);
      end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; skip_params = 1'b0; abort = 1'b0; nn_result = 8'h00;
    for (int i = 0; i < 32; i++) mem[i] = 8'hEE;
    for (int i = 0; i < NI; i++) mem[i] = 8'(10 - i);
    for (int n = 0; n < 4; n++) begin
      mem[NI + 6*n] = 8'h00;
      for (int j = 1; j < 6; j++) mem[NI + 6*n + j] = 8'(4 - n);
    end
    test_reset();
    test_full_load();
    test_skip_load();
    test_skip_after_reset();
    test_back_to_back();
    test_abort();
    test_abort_idle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nn_load_sequencer.md
Name: nn_load_sequencer

Overview:
- Controller that sequences one inference of `neural_network`. It fetches input and parameter bytes from a byte-wide parameter memory and streams them onto the network's `data_in`.
- It pulses `changes` after the input block and again after the parameter block, waits a fixed latency, then captures `network_outputs`.
- Sits between the host/parameter RAM and `neural_network`; the host issues `start` and reads back `result`.

Parameters:
- N_INPUTS, 4, number of input bytes per load.
- N_NEURONS, 4, number of neurons; each takes N_INPUTS+2 bytes (th, b, w[N_INPUTS-1..0]).
- DW, 8, data width.
- AW, 5, memory address width; must hold N_INPUTS + N_NEURONS*(N_INPUTS+2) - 1.
- RESULT_WAIT, 2, cycles from the second `changes` pulse to the `network_outputs` sample.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request one sequence; sampled only in IDLE.
- skip_params  in  1  sampled with start; 1 means reload inputs only and reuse weights.
- abort  in  1  synchronous abort to IDLE.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  AW  memory read address.
- mem_rdata  in  DW  read data, valid the cycle after mem_rd.
- nn_data  out  DW  byte to the `data_in` port of `neural_network`.
- nn_valid  out  1  nn_data carries a byte this cycle.
- nn_changes  out  1  one-cycle pulse to `changes`.
- nn_result  in  DW  from `network_outputs`.
- result  out  DW  captured network output.
- result_valid  out  1  one-cycle pulse when result updates.
- busy  out  1  sequence in progress.

Behaviour:
- Reset (reset=0 at an edge):
  - mem_rd, mem_addr, nn_data, nn_valid, nn_changes, result, result_valid and busy all go to 0.
  - FSM goes to IDLE; the params_loaded flag clears.
- Memory map:
  - Addresses 0..N_INPUTS-1 hold x[N_INPUTS-1]..x[0].
  - Next P = N_NEURONS*(N_INPUTS+2) addresses hold neurons in order N_NEURONS-1 down to 0, each laid out as th, b, w[N_INPUTS-1]..w[0].
- FSM states: IDLE, RD_X, PULSE_X, RD_P, PULSE_P, WAIT_RES, DONE.
- Cycle 0 is the edge where start=1 is sampled in IDLE. With NI=N_INPUTS:
  - busy=1 from cycle 1.
  - mem_rd=1 in cycles 1..NI, with mem_addr=0..NI-1.
  - nn_valid=1 in cycles 3..2+NI, with nn_data = bytes addr 0..NI-1 (two-cycle read-to-output latency).
  - nn_changes=1 in cycle C1=3+NI.
- Full load (skip_params=0):
  - mem_rd=1 in cycles 2+NI..1+NI+P, with mem_addr=NI..NI+P-1.
  - nn_valid=1 in cycles 4+NI..3+NI+P.
  - nn_changes=1 in cycle C2=4+NI+P.
  - params_loaded is set.
- Skip load: if skip_params=1 and params_loaded=1, the parameter phase is omitted and C2=C1. If params_loaded=0, skip_params is ignored and a full load is done.
- Result capture:
  - nn_result is sampled at the edge ending cycle C2+RESULT_WAIT.
  - In cycle C2+RESULT_WAIT+1: result holds the sample, result_valid=1 (single cycle), busy=0, FSM is back in IDLE.
  - A start sampled in that cycle is accepted.
- Defaults: C1=7, C2=32, result_valid in cycle 35. Skip path: result_valid in cycle 10.
- Output idle values: nn_data=0 whenever nn_valid=0. nn_changes is never asserted together with nn_valid. mem_addr holds its last value when mem_rd=0.
- start while busy: ignored, with no queueing.
- abort=1 while busy:
  - Next cycle: FSM in IDLE, busy=0, mem_rd=0, nn_valid=0, nn_changes=0.
  - No result_valid is produced; result is unchanged.
  - params_loaded clears if the abort occurs before C2.
  - abort in IDLE has no effect.
- abort and start together in IDLE: abort wins, start is dropped.
- reset=0 mid-sequence: same as power-on reset. result clears to 0 and params_loaded clears.
- result holds between sequences; it changes only on result_valid or reset.

Test Plan:
- Full load. Memory is 10,9,8,7 then per neuron 3..0: {0,4,4,4,4,4}, {0,3,3,3,3,3}, {0,2,2,2,2,2}, {0,1,1,1,1,1}. Stub drives nn_result=0x5A; pulse start.
  -> nn_data = 10,9,8,7 in cycles 3-6; nn_changes in cycle 7; the 24 param bytes in cycles 8-31 in memory order; nn_changes in cycle 32; result=0x5A with result_valid in cycle 35; busy high in cycles 1-34.
- After the full load, start with skip_params=1 and nn_result=0x33.
  -> Only 4 mem reads; nn_changes in cycle 7 only; result=0x33 with result_valid in cycle 10.
- After reset, start with skip_params=1.
  -> A full 28-read load is performed; result_valid in cycle 35.
- start pulses in cycles 5 and 20 of a running sequence.
  -> Ignored; exactly one result_valid.
  - A start sampled in the result_valid cycle begins a new sequence with mem_addr=0 in the next cycle.
- abort in cycle 15.
  -> Cycle 16: busy=0, nn_valid=0, no nn_changes; result keeps its old value.
  - A following start with skip_params=1 performs a full load.
- reset=0 in cycle 20.
  -> All outputs 0 in cycle 21; result=0; no nn_changes pulse afterward until the next start.
